demux_rr_scheduler: RTL and testbench
=====================================

# demux_rr_scheduler

Round-robin scheduler that shares one serial input stream among 16 destination channels through a 1-to-N demultiplexing datapath. Destinations request service; the block grants one destination at a time, locks the demux select for a fixed-length frame, and forwards each accepted input bit to the granted channel only. It sits between the serial source and the demux outputs and owns the select.

## Interface
- `N`, 16, number of destination channels; power of two, ≥2.
- `FRAME_LEN`, 8, bits per granted frame; ≥1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `dst_req`  input  N  per-channel request for a frame; level-sensitive.
- `in_valid`  input  1  source bit valid.
- `in_data`  input  1  source bit.
- `in_ready`  output  1  block accepts a bit this cycle.
- `sel`  output  $clog2(N)  currently granted channel.
- `out`  output  N  demuxed data; only bit `sel` may be 1.
- `out_valid`  output  N  one-hot strobe marking a delivered bit.
- `busy`  output  1  a frame is in progress.
- `frame_done`  output  1  one-cycle pulse after the last bit of a frame is delivered.
- `abort`  output  1  one-cycle pulse on a timed-out frame; tied 0 when the timeout feature is compiled out.

## Operation
- FSM states: IDLE, ARB, XFER.
- IDLE: leaves for ARB when `dst_req != 0`.
- ARB: lasts one cycle. Picks the first requesting channel strictly after `last_grant`, searching upward with wrap N-1→0. Loads `sel` and `last_grant`, clears the beat counter, then enters XFER. If `dst_req` has gone to 0 by this cycle, returns to IDLE.
- XFER:
  - `in_ready`=1. A beat is accepted when `in_valid & in_ready`.
  - Each accepted beat registers `out[sel]=in_data` and `out_valid[sel]=1`; all other bits are 0.
  - The counter increments per beat. The beat at count FRAME_LEN-1 is the last.
  - After the last beat, go to ARB if any `dst_req` is set, otherwise IDLE.
- The grant is locked for the whole frame. Deasserting `dst_req[sel]` mid-frame does not truncate the frame.
- Reset values: state IDLE, `last_grant`=N-1 (so channel 0 wins first), `sel`=0, counter 0. `in_ready`, `out`, `out_valid`, `busy`, `frame_done` and `abort` are all 0.
- Reset mid-frame drops the partial frame. No `frame_done` is issued.
- A single requester is re-granted back-to-back with one ARB cycle between its frames.
- `busy`=1 in ARB and XFER.

## Timing
- `in_ready` is a combinational decode of state==XFER.
- `out`, `out_valid`, `frame_done` and `abort` are registered.
- `dst_req` rising in IDLE at edge t: ARB at t+1, `in_ready` high at t+2.
- Data latency is one cycle: a beat accepted at edge k appears on `out` and `out_valid` during cycle k+1, then clears unless another beat is accepted.
- `frame_done` is asserted in the same cycle as the last `out_valid`.
- Gaps in `in_valid` stall the frame without limit, unless the timeout feature is enabled.
- Minimum frame period is FRAME_LEN+1 cycles, counting ARB.

## Configuration
- `DEMUX_SCHED_TIMEOUT_EN` defined:
  - In XFER, an idle counter counts consecutive cycles with `in_valid`=0 and resets on any accepted beat.
  - When it reaches `TIMEOUT_CYCLES` (package constant, 32), the frame is aborted.
  - On abort: pulse `abort` for one cycle, no `frame_done`, go to IDLE. `last_grant` keeps the aborted channel.
- Not defined: no idle counter, `abort` is constant 0, stalls last indefinitely.

## Structure
- Package `demux_sched_pkg` holds:
  - the state enum `sched_state_e` (IDLE, ARB, XFER);
  - `DEFAULT_N`=16;
  - `DEFAULT_FRAME_LEN`=8;
  - `TIMEOUT_CYCLES`=32.
- Sub-module `rr_arbiter`: combinational; inputs `req[N-1:0]` and `last[$clog2(N)-1:0]`; outputs `gnt_idx` and `gnt_valid`. The FSM, counters and output registers stay in the top module.

## Test plan
- Reset release with `dst_req`=16'h0001 and 8 bits 10110010 streamed: `sel`=0; `out_valid`=16'h0001 for 8 cycles; `out[0]` follows the data one cycle late; `frame_done` on the 8th.
- `dst_req`=16'h8011 held, continuous `in_valid`: grant order 0, 4, 15, 0; each frame is 8 beats separated by one ARB cycle.
- `dst_req`=16'h0020, drop the request after beat 3: channel 5 still gets all 8 beats, then state returns to IDLE.
- `in_valid` low for 5 cycles mid-frame: `in_ready` stays 1; the frame completes with exactly 8 `out_valid` pulses.
- Assert `rst_n` low at beat 4: all outputs 0 immediately; after release with `dst_req`=16'h0200 the grant goes to channel 9 with a fresh count and no `frame_done` for the dropped frame.
- Macro defined, `in_valid` low for 32 cycles mid-frame: `abort` pulses once, `busy` falls, no `frame_done`. Macro undefined, same stimulus: still in XFER, `abort`=0.

Source files
------------

// File: rtl/demux_rr_scheduler_pkg.sv
// demux_sched_pkg: shared types and constants for demux_rr_scheduler
//   sched_state_e     : scheduler FSM states
//   DEFAULT_N         : default number of destination channels
//   DEFAULT_FRAME_LEN : default bits per granted frame
//   TIMEOUT_CYCLES    : idle cycles before a frame is aborted (DEMUX_SCHED_TIMEOUT_EN)
package demux_sched_pkg;
   typedef enum logic [1:0] {IDLE, ARB, XFER} sched_state_e;
   localparam int DEFAULT_N = 16;
   localparam int DEFAULT_FRAME_LEN = 8;
   localparam int TIMEOUT_CYCLES = 32;
endpackage

// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if: request, serial source and demux output bundle
//   master : drives dst_req, in_valid, in_data; observes everything else
//   slave  : the scheduler side, drives in_ready, sel, out, out_valid, busy, frame_done, abort
interface demux_rr_scheduler_if import demux_sched_pkg::*; #(parameter int N = DEFAULT_N);
   localparam int SW = $clog2(N);
   logic [N-1:0]  dst_req;
   logic          in_valid;
   logic          in_data;
   logic          in_ready;
   logic [SW-1:0] sel;
   logic [N-1:0]  out;
   logic [N-1:0]  out_valid;
   logic          busy;
   logic          frame_done;
   logic          abort;
   modport master (output dst_req, in_valid, in_data,
                   input  in_ready, sel, out, out_valid, busy, frame_done, abort);
   modport slave  (input  dst_req, in_valid, in_data,
                   output in_ready, sel, out, out_valid, busy, frame_done, abort);
endinterface

// File: rtl/demux_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after last
//   req       : per-channel requests
//   last      : previously granted channel
//   gnt_idx   : chosen channel
//   gnt_valid : any request present
module rr_arbiter #(parameter int N = 16) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_valid
);
   localparam int SW = $clog2(N);
   always_comb begin
      gnt_idx = '0;
      gnt_valid = |req;
      // Scan farthest offset first so the nearest requester after last wins;
      // SW-bit addition wraps N-1 to 0, and offset N lands on last itself.
      for (int k = N; k > 0; k--)
         if (req[last + SW'(k)]) gnt_idx = last + SW'(k);
   end
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin grant of one serial stream to N demux channels in fixed frames
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_rr_scheduler_if.slave (requests, serial source, demux outputs, status)
//   Optional DEMUX_SCHED_TIMEOUT_EN: abort a frame after TIMEOUT_CYCLES consecutive idle cycles.
module demux_rr_scheduler import demux_sched_pkg::*; #(
   parameter int N = DEFAULT_N,
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
   input logic clk,
   input logic rst_n,
   demux_rr_scheduler_if.slave bus
);
   localparam int SW = $clog2(N);
   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   sched_state_e  r_state;
   logic [SW-1:0] r_sel, r_last, w_gnt_idx;
   logic          w_gnt_valid;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_out, r_out_valid;
   logic          r_frame_done;
   logic          w_beat, w_last_beat;
   rr_arbiter #(.N(N)) u_arb (
      .req(bus.dst_req),
      .last(r_last),
      .gnt_idx(w_gnt_idx),
      .gnt_valid(w_gnt_valid)
   );
   assign w_beat = bus.in_valid & (r_state == XFER);
   assign w_last_beat = w_beat && (r_cnt == CW'(FRAME_LEN - 1));
`ifdef DEMUX_SCHED_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [IW-1:0] r_idle;
   logic          r_abort;
   logic          w_timeout;
   // The cycle that would make the idle run TIMEOUT_CYCLES long triggers the abort.
   assign w_timeout = (r_state == XFER) && !w_beat && (r_idle == IW'(TIMEOUT_CYCLES - 1));
   assign bus.abort = r_abort;
`else
   assign bus.abort = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel <= '0;
         r_last <= SW'(N - 1);
         r_cnt <= '0;
         r_out <= '0;
         r_out_valid <= '0;
         r_frame_done <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
         r_idle <= '0;
         r_abort <= 1'b0;
`endif
      end else begin
         r_out <= '0;
         r_out_valid <= '0;
         r_frame_done <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
         r_abort <= 1'b0;
`endif
         case (r_state)
            IDLE: r_state <= (|bus.dst_req) ? ARB : IDLE;
            ARB: begin
               r_state <= w_gnt_valid ? XFER : IDLE;
               if (w_gnt_valid) begin
                  r_sel <= w_gnt_idx;
                  r_last <= w_gnt_idx;
               end
               r_cnt <= '0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
               r_idle <= '0;
`endif
            end
            XFER: begin
               if (w_beat) begin
                  r_out[r_sel] <= bus.in_data;
                  r_out_valid[r_sel] <= 1'b1;
                  r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                  r_idle <= '0;
`endif
                  if (w_last_beat) begin
                     r_frame_done <= 1'b1;
                     r_state <= (|bus.dst_req) ? ARB : IDLE;
                  end
               end
`ifdef DEMUX_SCHED_TIMEOUT_EN
               else if (w_timeout) begin
                  r_abort <= 1'b1;
                  r_state <= IDLE;
               end else r_idle <= r_idle + 1'b1;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready = (r_state == XFER);
   assign bus.busy = (r_state != IDLE);
   assign bus.sel = r_sel;
   assign bus.out = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: directed self-checking bench for demux_rr_scheduler
module tb_demux_rr_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   demux_rr_scheduler_if #(.N(16)) bus();
   demux_rr_scheduler #(.N(16), .FRAME_LEN(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      step();
      rst_n = 1'b1;
   endtask
   // Entered with the DUT in ARB; runs one 8-beat frame on channel ch.
   task automatic frame(input int ch, input logic [7:0] pat, input int drop_at, input int gap_at, input int gap_len);
      step();
      chk("xfer_sel", 32'(bus.sel), ch);
      chk("xfer_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < 8; i++) begin
         if (i == drop_at) bus.dst_req = '0;
         if (i == gap_at) begin
            bus.in_valid = 1'b0;
            repeat (gap_len) begin
               step();
               chk("gap_ready", 32'(bus.in_ready), 1);
               chk("gap_out_valid", 32'(bus.out_valid), 0);
            end
         end
         bus.in_valid = 1'b1;
         bus.in_data = pat[7-i];
         step();
         chk("beat_out_valid", 32'(bus.out_valid), 32'(1) << ch);
         chk("beat_out", 32'(bus.out), 32'(pat[7-i]) << ch);
         chk("beat_frame_done", 32'(bus.frame_done), (i == 7) ? 1 : 0);
      end
   endtask
   initial begin
      bus.dst_req = 16'h0001;
      bus.in_valid = 1'b0;
      bus.in_data = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_sel", 32'(bus.sel), 0);
      chk("rst_frame_done", 32'(bus.frame_done), 0);
      chk("rst_abort", 32'(bus.abort), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("s1_arb_busy", 32'(bus.busy), 1);
      chk("s1_arb_ready", 32'(bus.in_ready), 0);
      frame(0, 8'b10110010, 7, -1, 0);
      chk("s1_idle", 32'(bus.busy), 0);
      do_reset();
      bus.dst_req = 16'h8011;
      bus.in_valid = 1'b1;
      step();
      chk("s2_arb0", 32'(bus.busy & ~bus.in_ready), 1);
      frame(0, 8'hA5, -1, -1, 0);
      chk("s2_arb1", 32'(bus.busy & ~bus.in_ready), 1);
      frame(4, 8'h5A, -1, -1, 0);
      chk("s2_arb2", 32'(bus.busy & ~bus.in_ready), 1);
      frame(15, 8'hC3, -1, -1, 0);
      chk("s2_arb3", 32'(bus.busy & ~bus.in_ready), 1);
      frame(0, 8'h81, 7, -1, 0);
      chk("s2_idle", 32'(bus.busy), 0);
      do_reset();
      bus.in_valid = 1'b0;
      bus.dst_req = 16'h0020;
      step();
      frame(5, 8'h3C, 4, -1, 0);
      chk("s3_idle", 32'(bus.busy), 0);
      step();
      chk("s3_idle2", 32'(bus.busy), 0);
      chk("s3_quiet", 32'(bus.out_valid), 0);
      bus.dst_req = 16'h0002;
      step();
      frame(1, 8'hF0, 7, 3, 5);
      chk("s4_idle", 32'(bus.busy), 0);
      do_reset();
      bus.dst_req = 16'h0100;
      step();
      step();
      chk("s5_sel", 32'(bus.sel), 8);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 1'b1;
         step();
         chk("s5_beat", 32'(bus.out_valid), 32'h0100);
      end
      rst_n = 1'b0;
      bus.dst_req = 16'h0200;
      bus.in_valid = 1'b0;
      #1;
      chk("s5_rst_out_valid", 32'(bus.out_valid), 0);
      chk("s5_rst_out", 32'(bus.out), 0);
      chk("s5_rst_busy", 32'(bus.busy), 0);
      chk("s5_rst_ready", 32'(bus.in_ready), 0);
      chk("s5_rst_sel", 32'(bus.sel), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("s5_arb", 32'(bus.busy & ~bus.in_ready), 1);
      frame(9, 8'h96, 7, -1, 0);
      do_reset();
      bus.dst_req = 16'h0001;
      step();
      step();
      repeat (2) begin
         bus.in_valid = 1'b1;
         bus.in_data = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      bus.dst_req = '0;
      repeat (31) step();
      chk("s6_pre_abort", 32'(bus.abort), 0);
      chk("s6_pre_busy", 32'(bus.busy), 1);
      step();
`ifdef DEMUX_SCHED_TIMEOUT_EN
      chk("s6_abort", 32'(bus.abort), 1);
      chk("s6_busy", 32'(bus.busy), 0);
      chk("s6_frame_done", 32'(bus.frame_done), 0);
      step();
      chk("s6_abort_pulse", 32'(bus.abort), 0);
      chk("s6_idle", 32'(bus.busy), 0);
`else
      chk("s6_abort", 32'(bus.abort), 0);
      chk("s6_busy", 32'(bus.busy), 1);
      chk("s6_ready", 32'(bus.in_ready), 1);
      chk("s6_frame_done", 32'(bus.frame_done), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
